div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU operations in the execute stage.
- Takes the same operands and control code as the ALU and drives the execute result mux when a divide is in flight.
- Holds the pipeline through the busy signal so the divide does not sit on the single-cycle ALU path.
- Result encodings and corner cases match the ALU's combinational divide definitions bit for bit.

Parameters:
- ALUCTR_WIDTH, 5, width of the operation select code.
- DATA_WIDTH, 32, operand and result width; the iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- flush  input  1  synchronous abort of any in-flight operation.
- alu_ctr  input  ALUCTR_WIDTH  op code: 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
- alu_op1  input  DATA_WIDTH  dividend.
- alu_op2  input  DATA_WIDTH  divisor.
- busy  output  1  operation accepted and not yet completed.
- valid  output  1  single-cycle pulse; result is valid in this cycle.
- result  output  DATA_WIDTH  quotient or remainder.

Behaviour:
- Reset: async on rst_n=0. State=IDLE; busy=0, valid=0, result=0; all internal registers cleared.
- Reset asserted mid-operation: the operation is discarded with no valid pulse.
- States: IDLE, CALC, FIX.
- Acceptance at edge E0: start=1, busy=0, flush=0 and alu_ctr is one of the four codes.
  - Latch op code, operand signs, magnitudes (absolute values for DIV/REM; raw for DIVU/REMU) and divisor.
  - Set busy=1.
  - Any other alu_ctr: start is ignored, state stays IDLE.
- Special cases, resolved at E0 with no iteration:
  - Divisor==0: DIV/DIVU result=all-ones; REM/REMU result=alu_op1.
  - Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
  - Result is registered at E1; valid=1 and busy=0 in the cycle after E1; state returns to IDLE.
- Normal path, CALC at E1..E32: restoring shift-subtract on a DATA_WIDTH+1-bit partial remainder, one quotient bit per edge, MSB first. A 6-bit counter counts 0..31.
- FIX at E33:
  - DIV: quotient negated if the operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - Unsigned ops: no sign correction.
  - Result is registered; valid=1 for exactly one cycle after E33; busy deasserts in that same cycle.
- Latency: 33 edges normal, 1 edge special case.
- A new start is accepted in the same cycle valid is high, since busy=0 then.
- start while busy=1: ignored. Operands are not re-sampled; inputs may change freely after acceptance.
- flush=1 at any edge: state=IDLE, busy=0, valid=0 at that edge. result keeps its previous value.
- flush and start in the same cycle: flush wins, nothing is accepted.
- result holds its last value between valid pulses.
- valid is never asserted without a preceding accepted start.
- Arithmetic is modulo 2^DATA_WIDTH.
- Signed quotient truncates toward zero.
- Invariant: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.

Test Plan:
- DIVU op1=100, op2=7 -> busy high 33 cycles, valid pulse with result=14. Same operands with REMU -> result=2.
- DIV op1=-20 (0xFFFFFFEC), op2=3 -> result=0xFFFFFFFA (-6). REM with the same operands -> result=0xFFFFFFFE (-2). REM op1=20, op2=-3 -> 2.
- DIVU op1=0x12345678, op2=0 -> valid one cycle after start, result=0xFFFFFFFF. REMU with the same operands -> result=0x12345678.
- DIV op1=0x80000000, op2=0xFFFFFFFF -> result=0x80000000 after 1 edge. REM with the same operands -> result=0.
- Flush at edge E10 of DIVU 1000/10 -> busy drops, no valid pulse, result unchanged.
  - Then a second start with DIVU 1000/10 -> result=100.
  - A start pulsed during busy is ignored.
- rst_n low at edge E20 -> busy=0, valid=0, result=0 immediately, without waiting for a clock edge. After release, back-to-back DIVU 0xFFFFFFFF/1 then REMU 7/7 -> results 0xFFFFFFFF then 0.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Takes the ALU operands and op code. While a divide is in flight, busy holds
// the pipeline. The result is presented with a one-cycle valid pulse.
// Corner cases follow the RV32M definitions:
//   - divide by zero
//   - signed overflow
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - request a new operation (sampled only while busy=0)
//   flush    - synchronous abort of any in-flight operation
//   alu_ctr  - op code: 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU
//   alu_op1  - dividend
//   alu_op2  - divisor
//   busy     - operation accepted and not yet completed
//   valid    - single-cycle pulse, result valid in this cycle
//   result   - quotient or remainder, held between valid pulses
module div_unit #(
  parameter int ALUCTR_WIDTH = 5,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    flush,
  input  logic [ALUCTR_WIDTH-1:0] alu_ctr,
  input  logic [DATA_WIDTH-1:0]   alu_op1,
  input  logic [DATA_WIDTH-1:0]   alu_op2,
  output logic                    busy,
  output logic                    valid,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam logic [ALUCTR_WIDTH-1:0] OP_DIV  = ALUCTR_WIDTH'(5'b01110);
  localparam logic [ALUCTR_WIDTH-1:0] OP_DIVU = ALUCTR_WIDTH'(5'b01111);
  localparam logic [ALUCTR_WIDTH-1:0] OP_REM  = ALUCTR_WIDTH'(5'b10000);
  localparam logic [ALUCTR_WIDTH-1:0] OP_REMU = ALUCTR_WIDTH'(5'b10001);

  localparam logic [5:0]            CNT_LAST = 6'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement negate when neg is set (modulo 2^DATA_WIDTH).
  function automatic logic [DATA_WIDTH-1:0] cond_neg(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  neg
  );
    return neg ? (ZERO - v) : v;
  endfunction

  state_t                state_r, state_nxt_s;

  logic                  op_ok_s, op_signed_s, op_rem_s;
  logic                  div_zero_s, ovf_s, special_s;
  logic [DATA_WIDTH-1:0] special_val_s, mag1_s, mag2_s;
  logic                  accept_s;

  logic                  is_rem_r, neg_q_r, neg_r_r, special_r;
  logic [DATA_WIDTH-1:0] special_val_r;
  logic [DATA_WIDTH-1:0] quo_r, rem_r, dvs_r;
  logic [5:0]            cnt_r;
  logic                  busy_r, valid_r;
  logic [DATA_WIDTH-1:0] result_r;

  logic [DATA_WIDTH:0]   shifted_s, diff_s;
  logic                  ge_s;
  logic [DATA_WIDTH-1:0] rem_nxt_s, quo_nxt_s, fix_val_s;

  // Decode the op code and classify special cases from the live operands.
  always_comb begin
    op_ok_s       = 1'b0;
    op_signed_s   = 1'b0;
    op_rem_s      = 1'b0;
    case (alu_ctr)
      OP_DIV:  begin op_ok_s = 1'b1; op_signed_s = 1'b1; op_rem_s = 1'b0; end
      OP_DIVU: begin op_ok_s = 1'b1; op_signed_s = 1'b0; op_rem_s = 1'b0; end
      OP_REM:  begin op_ok_s = 1'b1; op_signed_s = 1'b1; op_rem_s = 1'b1; end
      OP_REMU: begin op_ok_s = 1'b1; op_signed_s = 1'b0; op_rem_s = 1'b1; end
      default: begin op_ok_s = 1'b0; op_signed_s = 1'b0; op_rem_s = 1'b0; end
    endcase

    div_zero_s = (alu_op2 == ZERO);
    ovf_s      = op_signed_s && (alu_op1 == MIN_NEG) && (alu_op2 == ALL_ONES);
    special_s  = div_zero_s || ovf_s;

    special_val_s = ZERO;
    if (div_zero_s) begin
      special_val_s = op_rem_s ? alu_op1 : ALL_ONES;
    end else if (ovf_s) begin
      special_val_s = op_rem_s ? ZERO : MIN_NEG;
    end else begin
      special_val_s = ZERO;
    end

    // Magnitudes: MIN_NEG maps onto itself, which is the correct unsigned magnitude.
    mag1_s = cond_neg(alu_op1, op_signed_s && alu_op1[DATA_WIDTH-1]);
    mag2_s = cond_neg(alu_op2, op_signed_s && alu_op2[DATA_WIDTH-1]);
  end

  // One restoring step: the trial remainder is DATA_WIDTH+1 bits wide.
  // Its top bit is the borrow that decides the quotient bit.
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    ge_s      = ~diff_s[DATA_WIDTH];
    rem_nxt_s = ge_s ? diff_s[DATA_WIDTH-1:0] : shifted_s[DATA_WIDTH-1:0];
    quo_nxt_s = {quo_r[DATA_WIDTH-2:0], ge_s};
  end

  // Final sign correction, or the precomputed special-case value.
  always_comb begin
    if (special_r) begin
      fix_val_s = special_val_r;
    end else if (is_rem_r) begin
      fix_val_s = cond_neg(rem_r, neg_r_r);
    end else begin
      fix_val_s = cond_neg(quo_r, neg_q_r);
    end
  end

  // Next-state logic; flush overrides everything, including a new start.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && op_ok_s) begin
            accept_s    = 1'b1;
            state_nxt_s = special_s ? FIX : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = CALC;
          end
        end
        FIX:     state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iteration, result and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rem_r      <= 1'b0;
      neg_q_r       <= 1'b0;
      neg_r_r       <= 1'b0;
      special_r     <= 1'b0;
      special_val_r <= ZERO;
      quo_r         <= ZERO;
      rem_r         <= ZERO;
      dvs_r         <= ZERO;
      cnt_r         <= 6'd0;
      busy_r        <= 1'b0;
      valid_r       <= 1'b0;
      result_r      <= ZERO;
    end else begin
      valid_r <= 1'b0;
      if (flush) begin
        busy_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              is_rem_r      <= op_rem_s;
              neg_q_r       <= op_signed_s && (alu_op1[DATA_WIDTH-1] ^ alu_op2[DATA_WIDTH-1]);
              neg_r_r       <= op_signed_s && alu_op1[DATA_WIDTH-1];
              special_r     <= special_s;
              special_val_r <= special_val_s;
              quo_r         <= mag1_s;
              rem_r         <= ZERO;
              dvs_r         <= mag2_s;
              cnt_r         <= 6'd0;
              busy_r        <= 1'b1;
            end else begin
              busy_r <= 1'b0;
            end
          end
          CALC: begin
            quo_r <= quo_nxt_s;
            rem_r <= rem_nxt_s;
            cnt_r <= cnt_r + 6'd1;
          end
          FIX: begin
            result_r <= fix_val_s;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
          end
          default: begin
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_r;
  assign valid  = valid_r;
  assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Expected results are queued when an operation is driven and checked when valid pulses.
module tb_div_unit;

  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_DIVU = 5'b01111;
  localparam logic [4:0] OP_REM  = 5'b10000;
  localparam logic [4:0] OP_REMU = 5'b10001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [4:0]  alu_ctr;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        prev_valid = 1'b0;

  div_unit #(.ALUCTR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .alu_ctr(alu_ctr), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference divide following the RV32M definitions.
  function automatic logic [31:0] ref_div(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (c)
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 32'd0) ? a : a % b;
      OP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
      OP_REM:  return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard: compare every valid pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check(tag_q.pop_front(), result, exp_q.pop_front());
      end
    end
    if (valid && prev_valid) check("valid_pulse_width", 32'd2, 32'd1);
    prev_valid <= valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one operation, check busy every cycle, latency, and busy release.
  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input bit poke);
    int n;
    @(negedge clk);
    start = 1'b1; alu_ctr = c; alu_op1 = a; alu_op2 = b;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(posedge clk); #1;
    start = 1'b0; alu_op1 = $urandom; alu_op2 = $urandom; alu_ctr = OP_REMU;
    n = 0;
    while (!valid && n < 100) begin
      start = 1'b0;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (poke && n == 5) begin
        start = 1'b1; alu_ctr = OP_DIVU; alu_op1 = 32'd5; alu_op2 = 32'd1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_at_valid"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    alu_ctr = 5'd0; alu_op1 = 32'd0; alu_op2 = 32'd0;
    #12;
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_valid",  {31'd0, valid}, 32'd0);
    check("reset_result", result,         32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2,  33, 1'b0);
    run_op("divu_div0",  OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_div0",  OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1'b0);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run_op("div_m20_3",  OP_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 1'b0);
    run_op("rem_m20_3",  OP_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("rem_20_m3",  OP_REM,  32'd20, 32'hFFFF_FFFD, 32'd2, 33, 1'b0);

    // Flush at E10; a start in the same cycle must lose to the flush.
    @(negedge clk);
    start = 1'b1; alu_ctr = OP_DIVU; alu_op1 = 32'd1000; alu_op2 = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1; alu_ctr = OP_DIVU; alu_op1 = 32'd8; alu_op2 = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_busy",   {31'd0, busy},  32'd0);
    check("flush_valid",  {31'd0, valid}, 32'd0);
    check("flush_result", result,         32'd2);
    repeat (40) @(posedge clk);
    #1;
    check("flush_stays_idle", {31'd0, busy}, 32'd0);
    check("flush_result_held", result, 32'd2);

    run_op("divu_1000_10_poke", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b1);

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [4:0]  c;
      logic [31:0] a, b;
      int          lat;
      case (i % 4)
        0: c = OP_DIV;
        1: c = OP_DIVU;
        2: c = OP_REM;
        default: c = OP_REMU;
      endcase
      a = $urandom;
      b = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 3) b = 32'hFFFF_FFF9;
      lat = (b == 32'd0 || ((c == OP_DIV || c == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      run_op($sformatf("rand%0d", i), c, a, b, ref_div(c, a, b), lat, 1'b0);
    end

    // Unsupported op code: start ignored.
    @(negedge clk);
    start = 1'b1; alu_ctr = 5'b00000; alu_op1 = 32'd9; alu_op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_op_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; alu_ctr = OP_DIVU; alu_op1 = 32'd1000; alu_op2 = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'd0, busy},  32'd0);
    check("async_rst_valid",  {31'd0, valid}, 32'd0);
    check("async_rst_result", result,         32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_ff_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("remu_7_7",  OP_REMU, 32'd7, 32'd7, 32'd0, 33, 1'b0);

    repeat (40) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
